// File: rtl/rename_commit_queue_if.sv
// Handshake bundle between the rename stage and the in-order commit queue.
//   enq_e/enq_name/enq_ready/enq_tag : allocate a new entry at the tail
//   done_e/done_tag                  : writeback completion for one entry
//   squash_e/squash_tag              : drop every entry younger than squash_tag
//   flush_e                          : drop every uncommitted entry
//   fe/name_f                        : registered free pulse back to the rename file
//   count                            : occupied entries
interface rename_commit_queue_if #(
  parameter int unsigned NameWidth = 5,
  parameter int unsigned PtrWidth  = 4
);
  logic                 enq_e;
  logic [NameWidth-1:0] enq_name;
  logic                 enq_ready;
  logic [PtrWidth-1:0]  enq_tag;
  logic                 done_e;
  logic [PtrWidth-1:0]  done_tag;
  logic                 squash_e;
  logic [PtrWidth-1:0]  squash_tag;
  logic                 flush_e;
  logic                 fe;
  logic [NameWidth-1:0] name_f;
  logic [PtrWidth:0]    count;

  modport master (
    output enq_e, enq_name, done_e, done_tag, squash_e, squash_tag, flush_e,
    input  enq_ready, enq_tag, fe, name_f, count
  );

  modport slave (
    input  enq_e, enq_name, done_e, done_tag, squash_e, squash_tag, flush_e,
    output enq_ready, enq_tag, fe, name_f, count
  );
endinterface

// File: rtl/rename_commit_queue.sv
// In-order commit queue behind the checkpointing rename register file. Records each newly
// allocated physical name in program order, marks entries done on writeback and retires the
// oldest done entry by pulsing fe/name_f so the rename file frees the superseded mapping.
// Supports squash-to-tag and full flush on misspeculation.
// Ports:
//   CLK    : clock, all state updates on posedge
//   RST    : synchronous reset, active-high
//   bus_io : rename_commit_queue_if.slave (enqueue, done, squash, flush, free pulse, count)
module rename_commit_queue #(
  parameter int unsigned NameWidth = 5,
  parameter int unsigned Depth     = 16,
  parameter int unsigned PtrWidth  = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  rename_commit_queue_if.slave   bus_io
);

  localparam logic [PtrWidth:0]   DepthCnt = (PtrWidth + 1)'(Depth);
  localparam logic [PtrWidth:0]   CntOne   = 1;
  localparam logic [PtrWidth-1:0] PtrOne   = 1;

  logic [Depth-1:0]     valid_q, valid_d;
  logic [Depth-1:0]     done_q, done_d;
  logic [NameWidth-1:0] name_q [Depth];
  logic [NameWidth-1:0] name_d [Depth];
  logic [PtrWidth-1:0]  head_q, head_d;
  logic [PtrWidth-1:0]  tail_q, tail_d;
  logic [PtrWidth:0]    count_q, count_d;
  logic                 fe_q, fe_d;
  logic [NameWidth-1:0] name_f_q, name_f_d;

  logic                 commit;
  logic                 enq_fire;
  logic [PtrWidth:0]    commit_cnt;
  logic [PtrWidth-1:0]  sq_age;
  logic [PtrWidth-1:0]  age;

  // No bypass: a full queue stays not-ready even while its head is retiring.
  assign bus_io.enq_ready = (count_q != DepthCnt) && !bus_io.squash_e && !bus_io.flush_e;
  assign bus_io.enq_tag   = tail_q;
  assign bus_io.fe        = fe_q;
  assign bus_io.name_f    = name_f_q;
  assign bus_io.count     = count_q;

  assign enq_fire   = bus_io.enq_e && bus_io.enq_ready;
  assign commit     = valid_q[head_q] && done_q[head_q];
  assign commit_cnt = {{PtrWidth{1'b0}}, commit};

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    name_d   = name_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q - commit_cnt;
    fe_d     = 1'b0;
    name_f_d = name_f_q;
    sq_age   = bus_io.squash_tag - head_q;
    age      = '0;

    // Head retirement proceeds regardless of squash/flush: the head is the oldest entry.
    if (commit) begin
      fe_d            = 1'b1;
      name_f_d        = name_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PtrOne;
    end

    if (bus_io.done_e && valid_q[bus_io.done_tag]) begin
      done_d[bus_io.done_tag] = 1'b1;
    end

    if (bus_io.flush_e) begin
      valid_d = '0;
      done_d  = '0;
      tail_d  = head_d;
      count_d = '0;
    end else if (bus_io.squash_e) begin
      if (valid_q[bus_io.squash_tag]) begin
        // Age relative to head orders entries across the wrap; older-or-equal survive.
        for (int unsigned i = 0; i < Depth; i++) begin
          age = PtrWidth'(i) - head_q;
          if (age > sq_age) begin
            valid_d[i] = 1'b0;
            done_d[i]  = 1'b0;
          end
        end
        tail_d  = bus_io.squash_tag + PtrOne;
        count_d = {1'b0, sq_age} + CntOne - commit_cnt;
      end
    end else if (enq_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      name_d[tail_q]  = bus_io.enq_name;
      tail_d          = tail_q + PtrOne;
      count_d         = count_q + CntOne - commit_cnt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      fe_q     <= 1'b0;
      name_f_q <= '0;
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      fe_q     <= fe_d;
      name_f_q <= name_f_d;
    end
  end

  // Name storage needs no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    name_q <= name_d;
  end

endmodule

// File: tb/tb_rename_commit_queue.sv
module tb_rename_commit_queue;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rename_commit_queue_if #(.NameWidth(5), .PtrWidth(4)) bus ();

  rename_commit_queue #(
    .NameWidth(5),
    .Depth    (16),
    .PtrWidth (4)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       enq;
    logic [4:0] name;
    logic       done;
    logic [3:0] dtag;
    logic       sq;
    logic [3:0] stag;
    logic       fl;
    logic       rdy;  // expected enq_ready with these inputs applied, before the edge
    logic       fe;   // expected after the edge
    logic [4:0] nf;
    logic [4:0] cnt;
    logic [3:0] tag;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t v(int r, int e, int nm, int d, int dt, int s, int st, int f,
                             int rdy, int fe, int nf, int cnt, int tag);
    vec_t x;
    x.rst  = 1'(r);
    x.enq  = 1'(e);
    x.name = 5'(nm);
    x.done = 1'(d);
    x.dtag = 4'(dt);
    x.sq   = 1'(s);
    x.stag = 4'(st);
    x.fl   = 1'(f);
    x.rdy  = 1'(rdy);
    x.fe   = 1'(fe);
    x.nf   = 5'(nf);
    x.cnt  = 5'(cnt);
    x.tag  = 4'(tag);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst            = 1'b0;
    bus.enq_e      = 1'b0;
    bus.enq_name   = '0;
    bus.done_e     = 1'b0;
    bus.done_tag   = '0;
    bus.squash_e   = 1'b0;
    bus.squash_tag = '0;
    bus.flush_e    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_fe", 32'(bus.fe), 0);
    chk("reset_name_f", 32'(bus.name_f), 0);
    chk("reset_count", 32'(bus.count), 0);
    chk("reset_tag", 32'(bus.enq_tag), 0);
    chk("reset_ready", 32'(bus.enq_ready), 1);

    // Enqueue 8,9,10; done head; free two cycles later.
    vq.push_back(v(0, 1,  8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(v(0, 1,  9, 0, 0, 0, 0, 0, 1, 0, 0, 2, 2));
    vq.push_back(v(0, 1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 8, 2, 3));
    // Out-of-order done, in-order frees.
    vq.push_back(v(1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 1,  8, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(v(0, 1,  9, 0, 0, 0, 0, 0, 1, 0, 0, 2, 2));
    vq.push_back(v(0, 1, 10, 0, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 1, 2, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 8, 2, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 9, 1, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 10, 0, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3));
    // Squash to tag 2 with a same-cycle enqueue; done on a squashed entry ignored.
    vq.push_back(v(1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) vq.push_back(v(0, 1, i + 1, 0, 0, 0, 0, 0, 1, 0, 0, i + 1, i + 1));
    vq.push_back(v(0, 1, 20, 0, 0, 1, 2, 0, 0, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 1, 4, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0, 3, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 3));
    // Head done, then flush: head still freed, tail lands on head+1.
    vq.push_back(v(0, 0,  0, 1, 1, 0, 0, 0, 1, 0, 0, 2, 3));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 2));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    // Reset with a done head and five entries queued.
    for (int i = 0; i < 5; i++) vq.push_back(v(0, 1, 11 + i, 0, 0, 0, 0, 0, 1, 0, 0, i + 1, i + 3));
    vq.push_back(v(0, 0,  0, 1, 2, 0, 0, 0, 1, 0, 0, 5, 7));
    vq.push_back(v(1, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // Squash to an invalid tag has no effect.
    vq.push_back(v(0, 1,  7, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(v(0, 0,  0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 1));
    vq.push_back(v(0, 0,  0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    vq.push_back(v(0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 1));

    foreach (vq[k]) begin
      rst            = vq[k].rst;
      bus.enq_e      = vq[k].enq;
      bus.enq_name   = vq[k].name;
      bus.done_e     = vq[k].done;
      bus.done_tag   = vq[k].dtag;
      bus.squash_e   = vq[k].sq;
      bus.squash_tag = vq[k].stag;
      bus.flush_e    = vq[k].fl;
      #1;
      chk($sformatf("v%0d_ready", k), 32'(bus.enq_ready), 32'(vq[k].rdy));
      tick();
      chk($sformatf("v%0d_fe", k), 32'(bus.fe), 32'(vq[k].fe));
      if (vq[k].fe) chk($sformatf("v%0d_name_f", k), 32'(bus.name_f), 32'(vq[k].nf));
      chk($sformatf("v%0d_count", k), 32'(bus.count), 32'(vq[k].cnt));
      chk($sformatf("v%0d_tag", k), 32'(bus.enq_tag), 32'(vq[k].tag));
    end

    // Fill to full, drop the 17th enqueue, free one and wrap the tail to tag 0.
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.enq_e    = 1'b1;
      bus.enq_name = 5'(i + 1);
      #1;
      chk($sformatf("fill%0d_tag", i), 32'(bus.enq_tag), 32'(i));
      chk($sformatf("fill%0d_ready", i), 32'(bus.enq_ready), 1);
      tick();
    end
    chk("full_count", 32'(bus.count), 16);
    chk("full_ready", 32'(bus.enq_ready), 0);
    chk("full_tag", 32'(bus.enq_tag), 0);
    bus.enq_name = 5'd30;
    tick();
    chk("drop_count", 32'(bus.count), 16);
    chk("drop_tag", 32'(bus.enq_tag), 0);
    bus.enq_e    = 1'b0;
    bus.done_e   = 1'b1;
    bus.done_tag = 4'd0;
    tick();
    bus.done_e = 1'b0;
    #1;
    chk("full_commit_no_bypass", 32'(bus.enq_ready), 0);
    tick();
    chk("full_commit_fe", 32'(bus.fe), 1);
    chk("full_commit_name", 32'(bus.name_f), 1);
    chk("full_commit_count", 32'(bus.count), 15);
    chk("full_commit_ready", 32'(bus.enq_ready), 1);
    chk("full_commit_tag", 32'(bus.enq_tag), 0);
    bus.enq_e    = 1'b1;
    bus.enq_name = 5'd31;
    tick();
    bus.enq_e = 1'b0;
    chk("wrap_count", 32'(bus.count), 16);
    chk("wrap_tag", 32'(bus.enq_tag), 1);
    chk("wrap_fe", 32'(bus.fe), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
